// File: rtl/wb_conmax_msel_rr.sv
//------------------------------------------------------------------------------
// Module   : wb_conmax_msel_rr
// Purpose  : Master-select arbiter for one slave port of a Wishbone crossbar.
//            NM masters, 2**PW priority levels, one round-robin pointer per
//            level. A grant is held for the whole bus cycle; an optional hold
//            limit forces a handover at a transfer boundary when an equal or
//            higher priority competitor is waiting.
// Ports    : clk_i      - clock, all state on rising edge
//            rst_i      - synchronous active-high reset
//            conf       - priority of master m in conf[m*PW +: PW]
//            req        - per-master request towards this slave
//            next       - end-of-transfer strobe (ack/err/rty of owner)
//            sel        - index of the granted master
//            gnt_vld    - grant valid
//            gnt_onehot - one-hot of sel, qualified by gnt_vld
//            gnt_pri    - priority level of the current owner
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_conmax_msel_rr #(
    parameter int NM       = 8,
    parameter int PW       = 2,
    parameter int SW       = 3,
    parameter int MAX_HOLD = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NM*PW-1:0] conf,
    input  logic [NM-1:0]    req,
    input  logic             next,
    output logic [SW-1:0]    sel,
    output logic             gnt_vld,
    output logic [NM-1:0]    gnt_onehot,
    output logic [PW-1:0]    gnt_pri
);

    localparam int c_LVLS = 2**PW;
    // Counter only needs to reach MAX_HOLD; keep one bit when unlimited.
    localparam int c_HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_HW-1:0] c_MAX_CNT = c_HW'(MAX_HOLD);
    localparam logic [SW-1:0]   c_PTR_RST = SW'(NM - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   w_sel_nxt;
    logic [PW-1:0]   r_pri;
    logic [PW-1:0]   w_pri_nxt;
    logic            r_vld;
    logic            w_vld_nxt;
    logic [c_HW-1:0] r_cnt;
    logic [c_HW-1:0] w_cnt_nxt;
    logic [c_HW-1:0] w_cnt_upd;
    logic [SW-1:0]   r_ptr [c_LVLS];
    logic            w_ptr_we;

    logic [PW-1:0]   w_pri_of [NM];
    logic [PW-1:0]   w_lvl;
    logic [SW-1:0]   w_win;
    logic            w_other;
    logic            w_rel_a;
    logic            w_rel_b;

    // Unpack the flat priority vector.
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            w_pri_of[m] = conf[m*PW +: PW];
        end
    end

    // Highest priority level among the requesting masters.
    always_comb begin
        w_lvl = '0;
        for (int m = 0; m < NM; m++) begin
            if (req[m] && (w_pri_of[m] > w_lvl)) begin
                w_lvl = w_pri_of[m];
            end
        end
    end

    // Round-robin search at level w_lvl, starting just after that level's
    // last winner and wrapping modulo NM. The last probed index is the
    // pointer itself, so a lone requester is always found.
    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        w_win = '0;
        for (int k = 1; k <= NM; k++) begin
            idx = SW'((int'(r_ptr[w_lvl]) + k) % NM);
            if (!found && req[idx] && (w_pri_of[idx] == w_lvl)) begin
                found = 1'b1;
                w_win = idx;
            end
        end
    end

    // Any other master waiting at or above the owner's level.
    always_comb begin
        w_other = 1'b0;
        for (int j = 0; j < NM; j++) begin
            if ((SW'(j) != r_sel) && req[j] && (w_pri_of[j] >= r_pri)) begin
                w_other = 1'b1;
            end
        end
    end

    // Saturating transfer count as it would be after this cycle's strobe.
    always_comb begin
        w_cnt_upd = r_cnt;
        if (next && (r_cnt != c_MAX_CNT)) begin
            w_cnt_upd = r_cnt + 1'b1;
        end
    end

    assign w_rel_a = ~req[r_sel];
    assign w_rel_b = (MAX_HOLD != 0) && next && (w_cnt_upd == c_MAX_CNT) && w_other;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_pri_nxt   = r_pri;
        w_vld_nxt   = r_vld;
        w_cnt_nxt   = r_cnt;
        w_ptr_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_OWN;
                    w_sel_nxt   = w_win;
                    w_pri_nxt   = w_lvl;
                    w_vld_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_ptr_we    = 1'b1;
                end
            end
            S_OWN: begin
                w_cnt_nxt = w_cnt_upd;
                // sel and gnt_pri deliberately keep their value on release.
                if (w_rel_a || w_rel_b) begin
                    w_state_nxt = S_IDLE;
                    w_vld_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_pri   <= '0;
            r_vld   <= 1'b0;
            r_cnt   <= '0;
            for (int l = 0; l < c_LVLS; l++) begin
                r_ptr[l] <= c_PTR_RST;
            end
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_pri   <= w_pri_nxt;
            r_vld   <= w_vld_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ptr_we) begin
                r_ptr[w_lvl] <= w_win;
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        if (r_vld) begin
            gnt_onehot[r_sel] = 1'b1;
        end
    end

    assign sel     = r_sel;
    assign gnt_vld = r_vld;
    assign gnt_pri = r_pri;

endmodule

`default_nettype wire
